// File: rtl/register_frame_spill_fill_unit.sv
// Maps the call/return frame stack onto NUM_BANKS banks; spills oldest/fills exposed frame via mem port, 2*REGS_PER_BANK+1 cycles each.
// op_ready_o low while spilling/filling. Define FRAME_STACK_ERROR_EN for a sticky error_o on stack over/underflow instead of wrap.
module register_frame_spill_fill_unit #(
  parameter int                NUM_BANKS     = 8,
  parameter int                REGS_PER_BANK = 16,
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] SPILL_BASE    = 32'h0000_F000
) (
  input  logic                              clock_i,
  input  logic                              reset_ni,
  input  logic                              enable_i,
  input  logic [6:0]                        opCode_i,
  output logic                              op_ready_o,
  output logic [5:0]                        regBankSelect_o,
  output logic [$clog2(NUM_BANKS)-1:0]      physBank_o,
  output logic [$clog2(NUM_BANKS):0]        resident_o,
  output logic                              rf_rd_en_o,
  output logic [$clog2(NUM_BANKS)-1:0]      rf_rd_bank_o,
  output logic [$clog2(REGS_PER_BANK)-1:0]  rf_rd_idx_o,
  input  logic [DATA_W-1:0]                 rf_rd_data_i,
  output logic                              rf_wr_en_o,
  output logic [$clog2(NUM_BANKS)-1:0]      rf_wr_bank_o,
  output logic [$clog2(REGS_PER_BANK)-1:0]  rf_wr_idx_o,
  output logic [DATA_W-1:0]                 rf_wr_data_o,
  output logic                              mem_valid_o,
  output logic                              mem_we_o,
  output logic [ADDR_W-1:0]                 mem_addr_o,
  output logic [DATA_W-1:0]                 mem_wdata_o,
  input  logic                              mem_ready_i,
  input  logic                              mem_rvalid_i,
  input  logic [DATA_W-1:0]                 mem_rdata_i
`ifdef FRAME_STACK_ERROR_EN
  ,
  output logic                              error_o
`endif
);
  localparam int LB  = $clog2(NUM_BANKS);
  localparam int LI  = $clog2(REGS_PER_BANK);
  localparam int BSH = $clog2(DATA_W/8);
  localparam logic [LB:0]   RES_FULL = (LB+1)'(NUM_BANKS);
  localparam logic [LB:0]   RES_ONE  = (LB+1)'(1);
  localparam logic [LI-1:0] IDX_ONE  = LI'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPILL_RD, S_SPILL_WR, S_FILL_REQ, S_FILL_WAIT, S_COMMIT
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        top_q, top_d, bottom_q, bottom_d;
  logic [LB:0]       res_q, res_d;
  logic [LI-1:0]     idx_q, idx_d;
  logic              fill_q, fill_d, held_q, held_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              is_push, is_pop, accept, push_err, pop_err, last_idx;
  logic [5:0]        fill_frame, xfer_frame;
  logic [ADDR_W-1:0] xfer_addr;

  assign is_push    = (opCode_i == 7'd11) || (opCode_i == 7'd13);
  assign is_pop     = (opCode_i == 7'd12) || (opCode_i == 7'd14);
  assign accept     = enable_i && (state_q == S_IDLE);
  assign last_idx   = (idx_q == '1);
  assign fill_frame = top_q - 6'd1;
  assign xfer_frame = fill_q ? fill_frame : bottom_q;
  // Frame areas are contiguous, so frame*REGS_PER_BANK+idx is a plain concatenation.
  assign xfer_addr  = SPILL_BASE + (ADDR_W'({xfer_frame, idx_q}) << BSH);

`ifdef FRAME_STACK_ERROR_EN
  logic error_q, error_d;
  assign push_err = (top_q == 6'd63);
  assign pop_err  = (top_q == 6'd0);
  assign error_d  = error_q | (accept && ((is_push && push_err) || (is_pop && pop_err)));
  assign error_o  = error_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) error_q <= 1'b0;
    else           error_q <= error_d;
  end
`else
  assign push_err = 1'b0;
  assign pop_err  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    top_d    = top_q;
    bottom_d = bottom_q;
    res_d    = res_q;
    idx_d    = idx_q;
    fill_d   = fill_q;
    held_d   = held_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_push && !push_err) begin
          if (res_q == RES_FULL) begin
            state_d = S_SPILL_RD;
            idx_d   = '0;
            fill_d  = 1'b0;
          end else begin
            top_d = top_q + 6'd1;
            res_d = res_q + RES_ONE;
          end
        end else if (accept && is_pop && !pop_err) begin
          if (res_q != RES_ONE) begin
            top_d = top_q - 6'd1;
            res_d = res_q - RES_ONE;
          end else begin
            state_d = S_FILL_REQ;
            idx_d   = '0;
            fill_d  = 1'b1;
          end
        end
      end
      S_SPILL_RD: state_d = S_SPILL_WR;
      S_SPILL_WR: begin
        // Read data is only valid in the first SPILL_WR cycle; hold it across ready stalls.
        if (!held_q) begin
          wdata_d = rf_rd_data_i;
          held_d  = 1'b1;
        end
        if (mem_ready_i) begin
          held_d  = 1'b0;
          idx_d   = idx_q + IDX_ONE;
          state_d = last_idx ? S_COMMIT : S_SPILL_RD;
        end
      end
      S_FILL_REQ: if (mem_ready_i) state_d = S_FILL_WAIT;
      S_FILL_WAIT: begin
        if (mem_rvalid_i) begin
          idx_d   = idx_q + IDX_ONE;
          state_d = last_idx ? S_COMMIT : S_FILL_REQ;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (fill_q) begin
          top_d    = top_q - 6'd1;
          bottom_d = bottom_q - 6'd1;
        end else begin
          top_d    = top_q + 6'd1;
          bottom_d = bottom_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      top_q    <= '0;
      bottom_q <= '0;
      res_q    <= RES_ONE;
      idx_q    <= '0;
      fill_q   <= 1'b0;
      held_q   <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      top_q    <= top_d;
      bottom_q <= bottom_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      fill_q   <= fill_d;
      held_q   <= held_d;
      wdata_q  <= wdata_d;
    end
  end

  assign op_ready_o      = (state_q == S_IDLE);
  assign regBankSelect_o = top_q;
  assign physBank_o      = top_q[LB-1:0];
  assign resident_o      = res_q;

  assign rf_rd_en_o   = (state_q == S_SPILL_RD);
  assign rf_rd_bank_o = rf_rd_en_o ? bottom_q[LB-1:0] : '0;
  assign rf_rd_idx_o  = rf_rd_en_o ? idx_q : '0;

  assign rf_wr_en_o   = (state_q == S_FILL_WAIT) && mem_rvalid_i;
  assign rf_wr_bank_o = rf_wr_en_o ? fill_frame[LB-1:0] : '0;
  assign rf_wr_idx_o  = rf_wr_en_o ? idx_q : '0;
  assign rf_wr_data_o = rf_wr_en_o ? mem_rdata_i : '0;

  assign mem_valid_o = (state_q == S_SPILL_WR) || (state_q == S_FILL_REQ);
  assign mem_we_o    = (state_q == S_SPILL_WR);
  assign mem_addr_o  = mem_valid_o ? xfer_addr : '0;
  assign mem_wdata_o = mem_we_o ? (held_q ? wdata_q : rf_rd_data_i) : '0;
endmodule

// File: tb/tb_register_frame_spill_fill_unit.sv
// Directed bench for register_frame_spill_fill_unit with reactive register-file and memory models.
module tb_register_frame_spill_fill_unit;
  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic [6:0]  opCode_i = 7'd0;
  logic [31:0] rf_rd_data_i = 32'hDEAD_BEEF;
  logic        mem_ready_i = 1'b1;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        op_ready_o, rf_rd_en_o, rf_wr_en_o, mem_valid_o, mem_we_o;
  logic [5:0]  regBankSelect_o;
  logic [2:0]  physBank_o, rf_rd_bank_o, rf_wr_bank_o;
  logic [3:0]  resident_o, rf_rd_idx_o, rf_wr_idx_o;
  logic [31:0] rf_wr_data_o, mem_addr_o, mem_wdata_o;
`ifdef FRAME_STACK_ERROR_EN
  logic        error_o;
`endif

  always #5 clk = ~clk;

  register_frame_spill_fill_unit dut (
    .clock_i(clk), .reset_ni(reset_ni), .enable_i(enable_i), .opCode_i(opCode_i),
    .op_ready_o(op_ready_o), .regBankSelect_o(regBankSelect_o), .physBank_o(physBank_o),
    .resident_o(resident_o), .rf_rd_en_o(rf_rd_en_o), .rf_rd_bank_o(rf_rd_bank_o),
    .rf_rd_idx_o(rf_rd_idx_o), .rf_rd_data_i(rf_rd_data_i), .rf_wr_en_o(rf_wr_en_o),
    .rf_wr_bank_o(rf_wr_bank_o), .rf_wr_idx_o(rf_wr_idx_o), .rf_wr_data_o(rf_wr_data_o),
    .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
`ifdef FRAME_STACK_ERROR_EN
    , .error_o(error_o)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  int stall_rem = 0;
  int stall_idx = 0;
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  logic [31:0] bank_m [8][16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] pat(input logic [2:0] b, input logic [3:0] i);
    return {16'hC0DE, 5'b0, b, 4'b0, i};
  endfunction

  task automatic op(input logic [6:0] code);
    enable_i = 1'b1;
    opCode_i = code;
    @(posedge clk);
    #1;
    enable_i = 1'b0;
    opCode_i = 7'd0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (!op_ready_o && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!op_ready_o) chk("idle_timeout", 0, 1);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  // Register file answers one cycle after a read; memory answers a read one cycle after acceptance.
  initial begin
    logic        hold_pend, nxt_rd, nxt_rv;
    logic [31:0] hold_addr, hold_wdata, nxt_rd_val, nxt_rdata;
    hold_pend = 1'b0;
    hold_addr = '0;
    hold_wdata = '0;
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 16; i++) bank_m[b][i] = 32'h0;
    forever begin
      @(negedge clk);
      if (hold_pend) begin
        chk("hold_valid", mem_valid_o, 1);
        chk("hold_addr", mem_addr_o, hold_addr);
        chk("hold_wdata", mem_wdata_o, hold_wdata);
      end
      hold_pend  = mem_valid_o && !mem_ready_i && reset_ni;
      hold_addr  = mem_addr_o;
      hold_wdata = mem_wdata_o;
      if (mem_valid_o && mem_we_o && !mem_ready_i && stall_rem > 0) stall_rem--;
      if (mem_valid_o && mem_ready_i) begin
        if (mem_we_o) begin
          wr_addr_q.push_back(mem_addr_o);
          wr_data_q.push_back(mem_wdata_o);
        end else begin
          rd_addr_q.push_back(mem_addr_o);
        end
      end
      if (rf_wr_en_o) bank_m[rf_wr_bank_o][rf_wr_idx_o] = rf_wr_data_o;
      nxt_rd     = rf_rd_en_o;
      nxt_rd_val = pat(rf_rd_bank_o, rf_rd_idx_o);
      nxt_rv     = mem_valid_o && mem_ready_i && !mem_we_o;
      nxt_rdata  = mem_addr_o ^ 32'h0000_00A5;
      @(posedge clk);
      #1;
      rf_rd_data_i = nxt_rd ? nxt_rd_val : 32'hDEAD_BEEF;
      mem_rvalid_i = nxt_rv;
      mem_rdata_i  = nxt_rv ? nxt_rdata : 32'h1234_5678;
      mem_ready_i  = !(stall_rem > 0 && wr_addr_q.size() == stall_idx);
    end
  end

  initial begin
    int cyc;
    logic found;
    repeat (2) @(posedge clk);
    #1 reset_ni = 1'b1;
    #1;
    chk("rst_op_ready", op_ready_o, 1);
    chk("rst_sel", regBankSelect_o, 0);
    chk("rst_phys", physBank_o, 0);
    chk("rst_resident", resident_o, 1);
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_rf_rd_en", rf_rd_en_o, 0);
    chk("rst_rf_wr_en", rf_wr_en_o, 0);
`ifdef FRAME_STACK_ERROR_EN
    chk("rst_error", error_o, 0);
`endif

    // Three pushes plus an unrelated opcode.
    op(7'd11);
    chk("push1_sel", regBankSelect_o, 1);
    op(7'd13);
    op(7'd11);
    op(7'd5);
    chk("push3_sel", regBankSelect_o, 3);
    chk("push3_phys", physBank_o, 3);
    chk("push3_resident", resident_o, 4);
    chk("push3_no_traffic", wr_addr_q.size() + rd_addr_q.size(), 0);

    // Fill all banks, then the 8th push spills frame 0.
    repeat (4) op(7'd13);
    chk("push7_resident", resident_o, 8);
    clear_logs();
    op(7'd11);
    chk("spill_busy", op_ready_o, 0);
    wait_idle(cyc);
    chk("spill_latency", cyc, 33);
    chk("spill_sel", regBankSelect_o, 8);
    chk("spill_phys", physBank_o, 0);
    chk("spill_resident", resident_o, 8);
    chk("spill_count", wr_addr_q.size(), 16);
    for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
      chk($sformatf("spill_addr%0d", i), wr_addr_q[i], 32'hF000 + 4 * i);
      chk($sformatf("spill_data%0d", i), wr_data_q[i], pat(3'd0, 4'(i)));
    end

    // Eight pops; the last refills frame 0 into bank 0.
    repeat (7) op(7'd12);
    chk("pop7_sel", regBankSelect_o, 1);
    chk("pop7_resident", resident_o, 1);
    clear_logs();
    op(7'd14);
    wait_idle(cyc);
    chk("fill_latency", cyc, 33);
    chk("fill_sel", regBankSelect_o, 0);
    chk("fill_resident", resident_o, 1);
    chk("fill_reads", rd_addr_q.size(), 16);
    chk("fill_no_writes", wr_addr_q.size(), 0);
    chk("fill_b0_i0", bank_m[0][0], 32'hF000 ^ 32'hA5);
    chk("fill_b0_i5", bank_m[0][5], 32'hF014 ^ 32'hA5);
    chk("fill_b0_i15", bank_m[0][15], 32'hF03C ^ 32'hA5);

    // Spill with a 3-cycle ready stall on the 5th write.
    repeat (7) op(7'd11);
    clear_logs();
    stall_idx = 4;
    stall_rem = 3;
    op(7'd13);
    wait_idle(cyc);
    chk("stall_latency", cyc, 36);
    chk("stall_count", wr_addr_q.size(), 16);
    if (wr_addr_q.size() > 5) begin
      chk("stall_addr4", wr_addr_q[4], 32'hF010);
      chk("stall_data4", wr_data_q[4], pat(3'd0, 4'd4));
      chk("stall_data5", wr_data_q[5], pat(3'd0, 4'd5));
    end
    chk("stall_sel", regBankSelect_o, 8);

    // Reset during the 10th write of the spill of frame 1.
    clear_logs();
    op(7'd11);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk);
      #2;
      if (mem_valid_o && mem_we_o && mem_addr_o == 32'hF064) found = 1'b1;
    end
    chk("spill10_seen", found, 1);
    #1 reset_ni = 1'b0;
    #1;
    chk("arst_mem_valid", mem_valid_o, 0);
    chk("arst_op_ready", op_ready_o, 1);
    chk("arst_sel", regBankSelect_o, 0);
    chk("arst_resident", resident_o, 1);
    #3 reset_ni = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    op(7'd11);
    chk("post_rst_ready", op_ready_o, 1);
    chk("post_rst_sel", regBankSelect_o, 1);
    chk("post_rst_resident", resident_o, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_spill", wr_addr_q.size(), 0);

    // Pop back to frame 0, then pop past the bottom of the stack.
    op(7'd12);
    chk("pop_to0_sel", regBankSelect_o, 0);
    clear_logs();
    op(7'd14);
`ifdef FRAME_STACK_ERROR_EN
    chk("under_ready", op_ready_o, 1);
    chk("under_error", error_o, 1);
    chk("under_sel", regBankSelect_o, 0);
    chk("under_resident", resident_o, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("under_no_reads", rd_addr_q.size(), 0);
`else
    wait_idle(cyc);
    chk("wrap_latency", cyc, 33);
    chk("wrap_sel", regBankSelect_o, 63);
    chk("wrap_phys", physBank_o, 7);
    chk("wrap_resident", resident_o, 1);
    chk("wrap_reads", rd_addr_q.size(), 16);
    if (rd_addr_q.size() > 0) chk("wrap_addr0", rd_addr_q[0], 32'hFFC0);
    chk("wrap_b7_i0", bank_m[7][0], 32'hFFC0 ^ 32'hA5);
    chk("wrap_b7_i15", bank_m[7][15], 32'hFFFC ^ 32'hA5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/register_frame_spill_fill_unit.md
# register_frame_spill_fill_unit

Consumer-side companion to the register frame counter. It tracks the logical register frame selected by call/return opcodes (11/13 push, 12/14 pop) and maps it onto NUM_BANKS physical register banks. When a push finds every physical bank occupied, it spills the oldest resident frame to memory. When a pop exposes a frame that is no longer resident, it fills that frame back from memory. It sits between decode, the banked register file and the data-memory port, and backpressures decode while a spill or fill is in progress.

## Interface
- NUM_BANKS, 8, physical register banks; power of two, 2..32
- REGS_PER_BANK, 16, registers per frame; power of two
- DATA_W, 32, register width
- ADDR_W, 32, memory address width
- SPILL_BASE, 32'h0000_F000, byte address of logical frame 0's spill area
- clock_i  in  1  clock; all state changes on the rising edge
- reset_ni  in  1  asynchronous, active-low reset
- enable_i  in  1  opcode valid
- opCode_i  in  7  decoded opcode
- op_ready_o  out  1  high only in IDLE; an opcode is accepted when enable_i && op_ready_o
- regBankSelect_o  out  6  current logical frame
- physBank_o  out  log2(NUM_BANKS)  regBankSelect_o mod NUM_BANKS
- resident_o  out  log2(NUM_BANKS)+1  number of resident frames
- rf_rd_en_o, rf_rd_bank_o, rf_rd_idx_o  out  1 / log2(NUM_BANKS) / log2(REGS_PER_BANK)  register-file spill read; data arrives one cycle later
- rf_rd_data_i  in  DATA_W  register-file read data
- rf_wr_en_o, rf_wr_bank_o, rf_wr_idx_o, rf_wr_data_o  out  fill write port
- mem_valid_o  out  1  memory request valid
- mem_we_o  out  1  1 = write (spill), 0 = read (fill)
- mem_addr_o  out  ADDR_W  request address
- mem_wdata_o  out  DATA_W  spill write data
- mem_ready_i  in  1  request accepted when mem_valid_o && mem_ready_i
- mem_rvalid_i, mem_rdata_i  in  1 / DATA_W  fill read response; one request outstanding at most
- error_o  out  1  sticky frame-stack error; present only with FRAME_STACK_ERROR_EN

## Operation
- Internal state: top (6-bit logical frame), bottom (oldest resident logical frame), resident count, register index, FSM.
- FSM states: IDLE, SPILL_RD, SPILL_WR, FILL_REQ, FILL_WAIT, COMMIT.
- Reset values: top = 0, bottom = 0, resident = 1. All outputs are 0 except op_ready_o = 1 and resident_o = 1.
- Opcodes other than 11–14 are accepted and have no effect.
- **Push accepted, resident < NUM_BANKS:** top+1, resident+1; stay in IDLE.
- **Push accepted, resident == NUM_BANKS:** go to SPILL_RD with index 0.
  - SPILL_RD: rf_rd_en_o for bank bottom mod NUM_BANKS at the current index.
  - SPILL_WR: hold mem_valid_o = 1, mem_we_o = 1 and mem_addr_o = SPILL_BASE + (bottom*REGS_PER_BANK + index)*(DATA_W/8) until mem_ready_i.
  - After the handshake, advance the index. Return to SPILL_RD, or after the last register go to COMMIT.
  - COMMIT: bottom+1, resident−1, then apply the pending push (top+1, resident+1), then go to IDLE.
- **Pop accepted, resident > 1:** top−1, resident−1.
- **Pop accepted, resident == 1 and top > bottom is impossible;** with bottom > 0 the pop requires a fill of frame top−1.
  - FILL_REQ: mem_valid_o = 1, mem_we_o = 0, address computed from logical frame top−1, held until mem_ready_i.
  - FILL_WAIT: on mem_rvalid_i, pulse rf_wr_en_o with mem_rdata_i to bank (top−1) mod NUM_BANKS.
  - After the last register go to COMMIT: top−1, bottom−1, resident unchanged, then IDLE.
- **Push at top == 63 or pop at top == 0 (bottom == 0):** see Configuration.
- mem_valid_o must not drop before mem_ready_i. The address and data are stable while valid is high.
- A mem_rvalid_i arriving outside FILL_WAIT is ignored.

## Timing
- Non-stalling push/pop: regBankSelect_o, physBank_o and resident_o update on the edge after acceptance.
- Spill latency with mem_ready_i tied high: 2*REGS_PER_BANK + 1 cycles from acceptance to the return to IDLE (33 cycles for defaults). op_ready_o is low throughout.
- Fill latency with ready high and rvalid on the cycle after the request: 2*REGS_PER_BANK + 1 cycles.
- Each extra cycle mem_ready_i or mem_rvalid_i is low adds exactly one cycle.
- Asserting reset_ni low mid-spill or mid-fill immediately forces all state and outputs to their reset values, including mem_valid_o = 0. Partially spilled data is abandoned.

## Configuration
- FRAME_STACK_ERROR_EN defined:
  - A push at top == 63 or a pop at top == 0 is accepted but has no effect.
  - error_o is set one cycle later and stays set until reset.
- FRAME_STACK_ERROR_EN undefined:
  - No error_o port.
  - top wraps modulo 64 (63+1 → 0, 0−1 → 63), with resident/bottom bookkeeping applied as normal.
  - An underflow pop at resident == 1 performs a fill of frame 63.

## Test plan
- Reset then 3 pushes (opcode 11, 13, 11) -> regBankSelect_o = 3, physBank_o = 3, resident_o = 4, no memory traffic.
- 8 pushes from reset (NUM_BANKS = 8) -> 8th push spills frame 0 (16 writes, addresses 0xF000..0xF03C); afterwards regBankSelect_o = 8, physBank_o = 0, resident_o = 8, op_ready_o low for 33 cycles.
- Continue with 8 pops, mem_rdata_i = address^0xA5 -> last pop fills frame 0 into bank 0 with the matching data, regBankSelect_o = 0.
- Spill with mem_ready_i low for 3 cycles on the 5th write -> mem_valid_o/addr/wdata held constant, latency 36 cycles.
- Pop at top 0 -> with macro: error_o = 1 and regBankSelect_o = 0; without macro: regBankSelect_o = 63 and a fill of frame 63 occurs.
- reset_ni pulsed low during the 10th spill write -> mem_valid_o drops asynchronously, outputs at reset values, next push completes with no spill.
